// File: rtl/popcount_frame_accumulator.sv
// Frame accumulator for the popcount stream.
// Sums per-word counts over a frame, tracks word count and the largest count,
// and offers one result per frame on a held valid/ready output. A result that
// closes while the previous one is still unaccepted is discarded and counted.
module popcount_frame_accumulator #(
    parameter  int CNT_WIDTH = 7,
    parameter  int FRAME_LEN = 16,
    localparam int SUM_WIDTH = CNT_WIDTH + $clog2(FRAME_LEN),
    localparam int WRD_WIDTH = $clog2(FRAME_LEN + 1)
) (
    input  logic                 clk_i,
    input  logic                 arstn_i,
    input  logic [CNT_WIDTH-1:0] cnt_i,
    input  logic                 cnt_val_i,
    input  logic                 frame_last_i,
    output logic [SUM_WIDTH-1:0] sum_o,
    output logic [WRD_WIDTH-1:0] words_o,
    output logic [CNT_WIDTH-1:0] max_o,
    output logic                 sum_val_o,
    input  logic                 sum_ready_i,
    output logic                 drop_o,
    output logic [15:0]          drop_cnt_o
);

    localparam logic [WRD_WIDTH-1:0] LAST_IDX = WRD_WIDTH'(FRAME_LEN - 1);

    typedef enum logic {IDLE  = 1'b0, ACCUM = 1'b1} acc_state_e;
    typedef enum logic {EMPTY = 1'b0, FULL  = 1'b1} out_state_e;

    acc_state_e             acc_state_q;
    out_state_e             out_state_q;
    logic [SUM_WIDTH-1:0]   sum_acc_q;
    logic [WRD_WIDTH-1:0]   words_acc_q;
    logic [CNT_WIDTH-1:0]   max_acc_q;

    logic [SUM_WIDTH-1:0]   sum_q;
    logic [WRD_WIDTH-1:0]   words_q;
    logic [CNT_WIDTH-1:0]   max_q;
    logic                   drop_q;
    logic [15:0]            drop_cnt_q;

    // Running values including the current word; these are also the frame
    // result when the current word closes the frame.
    logic [SUM_WIDTH-1:0]   sum_d;
    logic [WRD_WIDTH-1:0]   words_d;
    logic [CNT_WIDTH-1:0]   max_d;
    logic                   close;
    logic                   hs;

    // Fold the incoming word into the running frame values.
    always_comb begin
        sum_d   = sum_acc_q + SUM_WIDTH'(cnt_i);
        words_d = words_acc_q + WRD_WIDTH'(1);
        max_d   = (cnt_i > max_acc_q) ? cnt_i : max_acc_q;
        close   = cnt_val_i && (frame_last_i || (words_acc_q == LAST_IDX));
        hs      = (out_state_q == FULL) && sum_ready_i;
    end

    // Accumulate FSM: IDLE means no word of the current frame has arrived yet.
    // A closing word clears the accumulators so the next cycle starts fresh.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            acc_state_q <= IDLE;
            sum_acc_q   <= '0;
            words_acc_q <= '0;
            max_acc_q   <= '0;
        end else if (cnt_val_i) begin
            if (close) begin
                acc_state_q <= IDLE;
                sum_acc_q   <= '0;
                words_acc_q <= '0;
                max_acc_q   <= '0;
            end else begin
                acc_state_q <= ACCUM;
                sum_acc_q   <= sum_d;
                words_acc_q <= words_d;
                max_acc_q   <= max_d;
            end
        end
    end

    // Output FSM: one-deep result register. A close loads it when empty or
    // when the held result is being accepted on the same edge; otherwise the
    // new result is dropped and the saturating drop counter advances.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            out_state_q <= EMPTY;
            sum_q       <= '0;
            words_q     <= '0;
            max_q       <= '0;
            drop_q      <= 1'b0;
            drop_cnt_q  <= '0;
        end else begin
            drop_q <= 1'b0;
            if (close && (out_state_q == EMPTY || hs)) begin
                out_state_q <= FULL;
                sum_q       <= sum_d;
                words_q     <= words_d;
                max_q       <= max_d;
            end else if (close) begin
                drop_q <= 1'b1;
                if (drop_cnt_q != 16'hFFFF)
                    drop_cnt_q <= drop_cnt_q + 16'd1;
            end else if (hs) begin
                out_state_q <= EMPTY;
            end
        end
    end

    assign sum_o      = sum_q;
    assign words_o    = words_q;
    assign max_o      = max_q;
    assign sum_val_o  = (out_state_q == FULL);
    assign drop_o     = drop_q;
    assign drop_cnt_o = drop_cnt_q;

endmodule

// File: tb/tb_popcount_frame_accumulator.sv
// Bench for popcount_frame_accumulator: directed frames, a frame-level
// reference model checked every cycle, and literal expectations per scenario.
module tb_popcount_frame_accumulator;

    localparam int CW = 7;
    localparam int FL = 16;
    localparam int SW = CW + $clog2(FL);
    localparam int WW = $clog2(FL + 1);

    logic          clk = 1'b0;
    logic          arstn = 1'b0;
    logic [CW-1:0] cnt = '0;
    logic          val = 1'b0;
    logic          last = 1'b0;
    logic          rdy = 1'b0;
    logic [SW-1:0] sum_o;
    logic [WW-1:0] words_o;
    logic [CW-1:0] max_o;
    logic          sum_val_o;
    logic          drop_o;
    logic [15:0]   drop_cnt_o;

    int checks = 0;
    int failures = 0;
    bit go = 1'b0;

    popcount_frame_accumulator #(.CNT_WIDTH(CW), .FRAME_LEN(FL)) dut (
        .clk_i(clk), .arstn_i(arstn), .cnt_i(cnt), .cnt_val_i(val),
        .frame_last_i(last), .sum_o(sum_o), .words_o(words_o), .max_o(max_o),
        .sum_val_o(sum_val_o), .sum_ready_i(rdy), .drop_o(drop_o),
        .drop_cnt_o(drop_cnt_o)
    );

    always #5 clk = ~clk;

    // Reference model: the frame being collected as a list of word counts,
    // plus the presented result and drop bookkeeping.
    int f_words[$];
    int m_sum = 0, m_words = 0, m_max = 0, m_val = 0, m_drop = 0, m_dcnt = 0;

    always @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            f_words.delete();
            m_sum <= 0; m_words <= 0; m_max <= 0;
            m_val <= 0; m_drop <= 0; m_dcnt <= 0;
        end else begin
            automatic bit taken = (m_val != 0) && rdy;
            automatic int s = 0, mx = 0, n;
            m_drop <= 0;
            if (val) f_words.push_back(int'(cnt));
            n = f_words.size();
            if (val && (last || n == FL)) begin
                foreach (f_words[k]) begin
                    s += f_words[k];
                    if (f_words[k] > mx) mx = f_words[k];
                end
                f_words.delete();
                if (m_val == 0 || taken) begin
                    m_val <= 1; m_sum <= s; m_words <= n; m_max <= mx;
                end else begin
                    m_drop <= 1;
                    m_dcnt <= (m_dcnt == 65535) ? 65535 : m_dcnt + 1;
                end
            end else if (taken) begin
                m_val <= 0;
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (go) begin
            chk("m_sum_val", int'(sum_val_o), m_val);
            chk("m_sum", int'(sum_o), m_sum);
            chk("m_words", int'(words_o), m_words);
            chk("m_max", int'(max_o), m_max);
            chk("m_drop", int'(drop_o), m_drop);
            chk("m_drop_cnt", int'(drop_cnt_o), m_dcnt);
        end
    end

    // Drive one cycle of inputs at a negedge and return at the next negedge.
    task automatic step(input int c, input bit v, input bit l, input bit r);
        cnt = CW'(c); val = v; last = l; rdy = r;
        @(negedge clk);
    endtask

    task automatic res(input string tag, input int v, input int s, input int w, input int m);
        chk({tag, "_val"}, int'(sum_val_o), v);
        chk({tag, "_sum"}, int'(sum_o), s);
        chk({tag, "_words"}, int'(words_o), w);
        chk({tag, "_max"}, int'(max_o), m);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_val", int'(sum_val_o), 0);
        chk("rst_drop_cnt", int'(drop_cnt_o), 0);
        arstn = 1'b1;
        go = 1'b1;
        @(negedge clk);

        // 1) full 16-word frame, result one cycle after word 16, for one cycle
        for (int i = 0; i < FL; i++) begin
            chk("t1_no_early_val", int'(sum_val_o), 0);
            step(32, 1, 0, 1);
        end
        res("t1", 1, 512, 16, 32);
        step(0, 0, 1, 1);          // last without valid is ignored
        chk("t1_val_drop", int'(sum_val_o), 0);

        // 2) short frame closed by last, next frame starts with no bubble
        step(1, 1, 0, 1);
        step(5, 1, 0, 1);
        step(3, 1, 1, 1);
        res("t2", 1, 9, 3, 5);
        step(2, 1, 1, 1);          // accept + close on same edge
        res("t2_next", 1, 2, 1, 2);
        chk("t2_no_drop", int'(drop_o), 0);
        step(0, 0, 0, 1);

        // 3) single word from IDLE
        step(7, 1, 1, 1);
        res("t3", 1, 7, 1, 7);
        step(0, 0, 0, 1);

        // 4) held result, second frame dropped
        step(4, 1, 1, 0);
        res("t4a", 1, 4, 1, 4);
        step(6, 1, 1, 0);
        res("t4b", 1, 4, 1, 4);
        chk("t4_drop", int'(drop_o), 1);
        chk("t4_drop_cnt", int'(drop_cnt_o), 1);
        step(0, 0, 0, 0);
        chk("t4_drop_pulse", int'(drop_o), 0);
        res("t4c", 1, 4, 1, 4);
        step(0, 0, 0, 1);
        chk("t4_empty", int'(sum_val_o), 0);
        step(0, 0, 0, 1);
        chk("t4_stays_empty", int'(sum_val_o), 0);

        // 5) close on the accepting edge: stay full, no drop
        step(3, 1, 1, 0);
        res("t5a", 1, 3, 1, 3);
        step(9, 1, 1, 1);
        res("t5b", 1, 9, 1, 9);
        chk("t5_drop", int'(drop_o), 0);
        chk("t5_drop_cnt", int'(drop_cnt_o), 1);
        step(0, 0, 0, 1);

        // zero-count words still count; max-count words exercise sum width
        step(0, 1, 0, 1);
        step(0, 1, 1, 1);
        res("zero", 1, 0, 2, 0);
        for (int i = 0; i < FL; i++) step(127, 1, 0, 1);
        res("maxw", 1, 2032, 16, 127);
        step(10, 1, 0, 0);
        step(20, 1, 0, 0);
        step(15, 1, 1, 1);
        res("mix", 1, 45, 3, 20);
        step(0, 0, 0, 1);

        // 6) reset mid-frame loses the partial frame
        for (int i = 0; i < 5; i++) step(1, 1, 0, 1);
        cnt = '0; val = 1'b0; last = 1'b0;
        #2 arstn = 1'b0;
        #1;
        res("t6_rst", 0, 0, 0, 0);
        chk("t6_rst_drop_cnt", int'(drop_cnt_o), 0);
        @(negedge clk);
        arstn = 1'b1;
        @(negedge clk);
        for (int i = 0; i < FL; i++) step(1, 1, 0, 1);
        res("t6", 1, 16, 16, 1);
        step(0, 0, 0, 1);
        repeat (2) step(0, 0, 0, 0);

        go = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
